dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests from the core's ALU_MEM stage; it replaces the temporary dataFromRam tie-off feeding MEM_WB.
- Word-organised internal RAM with RV32 byte/half/word accesses selected by func3, sign/zero extension on loads, and misalignment and range error detection.
- Valid/ready handshake on both the request and response channels; configurable fixed access latency so the pipeline can exercise stall paths.

Parameters:
- ADDR_W, 6, byte-address width; matches the 6-bit PC/ROM address space.
- DEPTH, 16, number of 32-bit words; must satisfy DEPTH*4 <= 2**ADDR_W.
- LATENCY, 2, cycles spent in ACCESS; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetIn  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  responder can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqFunc3  in  3  RV32 funct3 of the load/store.
- reqAddr  in  ADDR_W  byte address.
- reqWData  in  32  store data, right-aligned.
- respValid  out  1  response present.
- respReady  in  1  consumer accepts the response.
- respRData  out  32  load result, extended to 32 bits; 0 for stores and errors.
- respErr  out  1  request was misaligned, out of range, or used an illegal func3.

Behaviour:
- States: IDLE, ACCESS, RESP, held in a 2-bit state register plus a 4-bit latency counter.
- Reset (resetIn=0), asynchronous:
  - state=IDLE, counter=0, reqReady=1, respValid=0, respRData=0, respErr=0.
  - RAM contents are not cleared.
  - A transaction in flight is aborted; a store whose commit edge has not occurred is not written.
- IDLE:
  - reqReady=1.
  - On an edge with reqValid=1, latch write, func3, addr, and wdata, and run the error check.
  - Error → go to RESP with respErr=1 and respRData=0, no RAM access; response appears 1 cycle after the accept edge.
  - No error → go to ACCESS with counter=LATENCY-1.
- ACCESS:
  - reqReady=0.
  - Counter decrements each edge; on the edge where counter==0, the access commits and the state moves to RESP.
  - Response appears LATENCY+1 edges after the accept edge.
- Commit, store:
  - Byte-enable write to word addr[ADDR_W-1:2].
  - SB (000) writes lane addr[1:0] with wdata[7:0].
  - SH (001) writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - SW (010) writes all four lanes.
  - respRData=0.
- Commit, load:
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend.
  - LW (010) returns the full word.
  - Selected lane(s) follow the same little-endian rule as stores.
- Error conditions:
  - Illegal func3: loads other than 000/001/010/100/101, stores other than 000/001/010.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index addr>>2 >= DEPTH.
- RESP:
  - respValid=1; respRData and respErr are held stable until respReady=1 on an edge, then go to IDLE.
  - respValid drops the same edge; respRData and respErr return to 0.
  - reqReady=0 throughout RESP, so a new request is accepted at the earliest on the edge after returning to IDLE (no same-cycle overlap).
- Throughput: at most one outstanding transaction; back-to-back best case is 1 request per LATENCY+2 cycles.
- Handshake rules:
  - reqValid without reqReady is ignored; the requester holds its fields stable until accepted.
  - A respReady pulse outside RESP has no effect.
- Read-after-write: a load accepted after a store's response returns the stored data.

Test Plan:
- Reset: resetIn=0 mid-ACCESS of SW 0xDEADBEEF to addr 0x08 → respValid=0 and reqReady=1 immediately; a later LW 0x08 returns the prior contents, not 0xDEADBEEF.
- Word round trip (LATENCY=2): SW 0x12345678 @0x04 then LW @0x04 → respRData=0x12345678 and respErr=0; respValid rises exactly 3 edges after each accept.
- Sub-word: SW 0x80FF7F01 @0x10; LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LH @0x12 → 0xFFFF80FF; LHU @0x10 → 0x00007F01.
- Partial store: SW 0 @0x14, SB 0xAB @0x15, SH 0xCDEF @0x16; LW @0x14 → 0xCDEFAB00.
- Errors:
  - LW @0x02 → respErr=1, respRData=0, respValid 1 edge after accept, RAM unchanged.
  - LH @0x01 → respErr=1.
  - func3=011 → respErr=1.
  - LW @0x40-4 with DEPTH=8 → respErr=1.
- Back-pressure: hold respReady=0 for 5 cycles after an LW response → respValid and respRData stay constant, reqReady stays 0, and a reqValid asserted meanwhile is accepted only after RESP→IDLE.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between the ALU_MEM stage and the data memory.
interface dmem_responder_if #(parameter int ADDR_W = 6);
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [2:0]        reqFunc3;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqWData;
    logic              respValid;
    logic              respReady;
    logic [31:0]       respRData;
    logic              respErr;
    modport master (output reqValid, reqWrite, reqFunc3, reqAddr, reqWData, respReady,
                    input  reqReady, respValid, respRData, respErr);
    modport slave  (input  reqValid, reqWrite, reqFunc3, reqAddr, reqWData, respReady,
                    output reqReady, respValid, respRData, respErr);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM serving RV32 byte/half/word loads and stores
// with fixed access latency and valid/ready handshakes on request and response.
module dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input logic             clk,
    input logic             resetIn,
    dmem_responder_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [2:0]      func3_q, func3_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [31:0]     mem [DEPTH];
    logic            bad_f3, misaligned, out_of_range, req_err, commit;
    logic [31:0]     word, load_val, store_word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [3:0]      be;
    always_comb begin
        bad_f3       = bus.reqWrite ? (bus.reqFunc3 > 3'd2)
                                    : !(bus.reqFunc3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned   = (bus.reqFunc3[1:0] == 2'b01 && bus.reqAddr[0]) ||
                       (bus.reqFunc3[1:0] == 2'b10 && bus.reqAddr[1:0] != 2'b00);
        out_of_range = 32'(bus.reqAddr[ADDR_W-1:2]) >= 32'(DEPTH);
        req_err      = bad_f3 || misaligned || out_of_range;
    end
    always_comb begin
        word     = mem[idx_q];
        byte_v   = word[{off_q, 3'b000} +: 8];
        half_v   = word[{off_q[1], 4'b0000} +: 16];
        load_val = (func3_q == 3'd0) ? {{24{byte_v[7]}}, byte_v} :
                   (func3_q == 3'd1) ? {{16{half_v[15]}}, half_v} :
                   (func3_q == 3'd4) ? {24'd0, byte_v} :
                   (func3_q == 3'd5) ? {16'd0, half_v} : word;
    end
    // Replicate store data across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        store_word = (func3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                     (func3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
        be         = (func3_q[1:0] == 2'b00) ? (4'b0001 << off_q) :
                     (func3_q[1:0] == 2'b01) ? (off_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        commit     = (state_q == ACCESS) && (cnt_q == 4'd0);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        func3_d = func3_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.reqValid) begin
                write_d = bus.reqWrite;
                func3_d = bus.reqFunc3;
                idx_d   = bus.reqAddr[IW+1:2];
                off_d   = bus.reqAddr[1:0];
                wdata_d = bus.reqWData;
                state_d = req_err ? RESP : ACCESS;
                cnt_d   = 4'(LATENCY - 1);
                err_d   = req_err;
                rdata_d = 32'd0;
            end
            ACCESS: begin
                state_d = commit ? RESP : ACCESS;
                cnt_d   = commit ? cnt_q : cnt_q - 4'd1;
                rdata_d = (commit && !write_q) ? load_val : 32'd0;
                err_d   = 1'b0;
            end
            RESP: if (bus.respReady) begin
                state_d = IDLE;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            func3_q <= 3'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            func3_q <= func3_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    // RAM is never cleared; reset forces IDLE so an uncommitted store is dropped.
    always_ff @(posedge clk) begin
        if (commit && write_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx_q][8*i +: 8] <= store_word[8*i +: 8];
    end
    assign bus.reqReady  = (state_q == IDLE);
    assign bus.respValid = (state_q == RESP);
    assign bus.respRData = rdata_q;
    assign bus.respErr   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven load/store vectors plus reset-abort and back-pressure sequences.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic resetIn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    dmem_responder_if #(.ADDR_W(6)) bus ();
    dmem_responder #(.ADDR_W(6), .DEPTH(8), .LATENCY(2)) dut (
        .clk(clk),
        .resetIn(resetIn),
        .bus(bus)
    );
    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        er;
        int          lat;
    } vec_t;
    vec_t vt[24];
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic xact(input logic w, input logic [2:0] f, input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqFunc3 = f;
        bus.reqAddr  = a;
        bus.reqWData = d;
        n = 0;
        while (!bus.reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        lat = 1;
        while (!bus.respValid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = bus.respRData;
        er = bus.respErr;
        @(negedge clk) bus.respReady = 1'b1;
        @(posedge clk);
        #1 bus.respReady = 1'b0;
    endtask
    logic [31:0] rd, held;
    logic        er;
    int          lat;
    initial begin
        vt[0]  = '{1, 3'd2, 6'h04, 32'h12345678, 32'h0,        0, 3};
        vt[1]  = '{0, 3'd2, 6'h04, 32'h0,        32'h12345678, 0, 3};
        vt[2]  = '{1, 3'd2, 6'h10, 32'h80FF7F01, 32'h0,        0, 3};
        vt[3]  = '{0, 3'd0, 6'h13, 32'h0,        32'hFFFFFF80, 0, 3};
        vt[4]  = '{0, 3'd4, 6'h13, 32'h0,        32'h00000080, 0, 3};
        vt[5]  = '{0, 3'd1, 6'h12, 32'h0,        32'hFFFF80FF, 0, 3};
        vt[6]  = '{0, 3'd5, 6'h10, 32'h0,        32'h00007F01, 0, 3};
        vt[7]  = '{0, 3'd0, 6'h11, 32'h0,        32'h0000007F, 0, 3};
        vt[8]  = '{1, 3'd2, 6'h14, 32'h0,        32'h0,        0, 3};
        vt[9]  = '{1, 3'd0, 6'h15, 32'hFFFFFFAB, 32'h0,        0, 3};
        vt[10] = '{1, 3'd1, 6'h16, 32'h1234CDEF, 32'h0,        0, 3};
        vt[11] = '{0, 3'd2, 6'h14, 32'h0,        32'hCDEFAB00, 0, 3};
        vt[12] = '{0, 3'd2, 6'h02, 32'h0,        32'h0,        1, 1};
        vt[13] = '{0, 3'd2, 6'h04, 32'h0,        32'h12345678, 0, 3};
        vt[14] = '{0, 3'd1, 6'h01, 32'h0,        32'h0,        1, 1};
        vt[15] = '{0, 3'd3, 6'h00, 32'h0,        32'h0,        1, 1};
        vt[16] = '{1, 3'd3, 6'h04, 32'hFFFFFFFF, 32'h0,        1, 1};
        vt[17] = '{1, 3'd4, 6'h04, 32'hFFFFFFFF, 32'h0,        1, 1};
        vt[18] = '{0, 3'd2, 6'h3C, 32'h0,        32'h0,        1, 1};
        vt[19] = '{0, 3'd2, 6'h20, 32'h0,        32'h0,        1, 1};
        vt[20] = '{1, 3'd1, 6'h15, 32'hFFFFFFFF, 32'h0,        1, 1};
        vt[21] = '{0, 3'd2, 6'h13, 32'h0,        32'h0,        1, 1};
        vt[22] = '{0, 3'd2, 6'h04, 32'h0,        32'h12345678, 0, 3};
        vt[23] = '{0, 3'd6, 6'h10, 32'h0,        32'h0,        1, 1};
        bus.reqValid  = 1'b0;
        bus.reqWrite  = 1'b0;
        bus.reqFunc3  = 3'd0;
        bus.reqAddr   = 6'd0;
        bus.reqWData  = 32'd0;
        bus.respReady = 1'b0;
        #1;
        chk("reset_reqReady", 32'(bus.reqReady), 32'd1);
        chk("reset_respValid", 32'(bus.respValid), 32'd0);
        chk("reset_respRData", bus.respRData, 32'd0);
        chk("reset_respErr", 32'(bus.respErr), 32'd0);
        repeat (2) @(negedge clk);
        resetIn = 1'b1;
        foreach (vt[i]) begin
            xact(vt[i].w, vt[i].f, vt[i].a, vt[i].d, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
        end
        // respReady pulse while idle must not produce a response
        @(negedge clk) bus.respReady = 1'b1;
        @(posedge clk);
        #1 bus.respReady = 1'b0;
        chk("idle_respReady_valid", 32'(bus.respValid), 32'd0);
        chk("idle_respReady_ready", 32'(bus.reqReady), 32'd1);
        // reset in the middle of a store's ACCESS phase drops the store
        xact(1'b1, 3'd2, 6'h08, 32'h11112222, rd, er, lat);
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b1;
        bus.reqFunc3 = 3'd2;
        bus.reqAddr  = 6'h08;
        bus.reqWData = 32'hDEADBEEF;
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        @(posedge clk);
        #1 resetIn = 1'b0;
        #1;
        chk("abort_respValid", 32'(bus.respValid), 32'd0);
        chk("abort_reqReady", 32'(bus.reqReady), 32'd1);
        @(negedge clk);
        @(negedge clk) resetIn = 1'b1;
        xact(1'b0, 3'd2, 6'h08, 32'h0, rd, er, lat);
        chk("abort_readback", rd, 32'h11112222);
        chk("abort_readback_err", 32'(er), 32'd0);
        // back-pressure: response held, a pending request waits for RESP->IDLE
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = 1'b0;
        bus.reqFunc3 = 3'd2;
        bus.reqAddr  = 6'h04;
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        lat = 1;
        while (!bus.respValid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp_latency", 32'(lat), 32'd3);
        held = bus.respRData;
        chk("bp_rdata", held, 32'h12345678);
        bus.reqValid = 1'b1;
        bus.reqAddr  = 6'h10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", c), 32'(bus.respValid), 32'd1);
            chk($sformatf("bp_hold%0d_rdata", c), bus.respRData, held);
            chk($sformatf("bp_hold%0d_reqReady", c), 32'(bus.reqReady), 32'd0);
        end
        @(negedge clk) bus.respReady = 1'b1;
        @(posedge clk);
        #1 bus.respReady = 1'b0;
        chk("bp_release_valid", 32'(bus.respValid), 32'd0);
        chk("bp_release_rdata", bus.respRData, 32'd0);
        chk("bp_release_reqReady", 32'(bus.reqReady), 32'd1);
        @(posedge clk);
        #1 bus.reqValid = 1'b0;
        chk("bp_accept_reqReady", 32'(bus.reqReady), 32'd0);
        lat = 1;
        while (!bus.respValid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("bp_second_latency", 32'(lat), 32'd3);
        chk("bp_second_rdata", bus.respRData, 32'h80FF7F01);
        @(negedge clk) bus.respReady = 1'b1;
        @(posedge clk);
        #1 bus.respReady = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
